seg_reader: RTL and testbench

- Reads a multiplexed seven-segment display bus (segment lines plus one-hot digit select) and recovers the BCD value shown on each digit.
- Inverse of the team's BCD-to-seven-segment decoder: it sits on the display side of a scanned display and feeds the captured digits back into the design.
- Typical uses: self-check of display drivers and loop-back in test boards.
- A digit is only captured after its pattern has been stable for a set number of cycles; illegal patterns raise a sticky error.

---
 rtl/seg_pkg.sv | 48 ++++
 rtl/seg_to_bcd.sv | 33 +++
 rtl/seg_reader.sv | 122 ++++++++++++
 tb/tb_seg_reader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment encoding table and bit order, used by both the
// segment encoder and the segment reader so the two directions stay in step.
package seg_pkg;

    // Bit positions inside the 7-bit {a,b,c,d,e,f,g} segment vector.
    localparam int SEG_A_BIT = 6;
    localparam int SEG_B_BIT = 5;
    localparam int SEG_C_BIT = 4;
    localparam int SEG_D_BIT = 3;
    localparam int SEG_E_BIT = 2;
    localparam int SEG_F_BIT = 1;
    localparam int SEG_G_BIT = 0;

    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef struct packed {
        logic       legal;
        logic [3:0] bcd;
    } seg_dec_t;

    // Forward direction, kept next to the table the reader decodes against.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    bcd_to_seg = SEG_0;
            4'd1:    bcd_to_seg = SEG_1;
            4'd2:    bcd_to_seg = SEG_2;
            4'd3:    bcd_to_seg = SEG_3;
            4'd4:    bcd_to_seg = SEG_4;
            4'd5:    bcd_to_seg = SEG_5;
            4'd6:    bcd_to_seg = SEG_6;
            4'd7:    bcd_to_seg = SEG_7;
            4'd8:    bcd_to_seg = SEG_8;
            4'd9:    bcd_to_seg = SEG_9;
            default: bcd_to_seg = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg_to_bcd.sv
// Combinational seven-segment pattern to BCD decoder; any pattern outside
// the ten digit shapes is reported as illegal.
module seg_to_bcd
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic [3:0] bcd
);

    seg_dec_t dec;

    always_comb begin
        dec = '{legal: 1'b1, bcd: 4'd0};
        case (seg)
            SEG_0:   dec.bcd = 4'd0;
            SEG_1:   dec.bcd = 4'd1;
            SEG_2:   dec.bcd = 4'd2;
            SEG_3:   dec.bcd = 4'd3;
            SEG_4:   dec.bcd = 4'd4;
            SEG_5:   dec.bcd = 4'd5;
            SEG_6:   dec.bcd = 4'd6;
            SEG_7:   dec.bcd = 4'd7;
            SEG_8:   dec.bcd = 4'd8;
            SEG_9:   dec.bcd = 4'd9;
            default: dec.legal = 1'b0;
        endcase
    end

    assign legal = dec.legal;
    assign bcd   = dec.bcd;

endmodule

// File: rtl/seg_reader.sv
// Recovers the BCD digits shown on a scanned seven-segment display bus,
// committing a digit only after its pattern has been stable for STABLE cycles.
module seg_reader
    import seg_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int STABLE     = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     dig_sel,
    input  logic                  err_clear,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  update,
    output logic                  error
);

    localparam int             CW       = $clog2(STABLE + 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(STABLE);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE - 1);

    logic [6:0]          s_seg_q, s_seg_d;
    logic [DIGITS-1:0]   s_sel_q, s_sel_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [DIGITS-1:0]   valid_q, valid_d;
    logic                update_q, update_d;
    logic                error_q, error_d;

    logic                same;
    logic                commit;
    logic                sel_none;
    logic                sel_multi;
    logic                new_err;
    logic                dec_legal;
    logic [3:0]          dec_bcd;

    seg_to_bcd u_dec (
        .seg   (s_seg_q),
        .legal (dec_legal),
        .bcd   (dec_bcd)
    );

    always_comb begin
        s_seg_d   = (ACTIVE_LOW != 0) ? ~seg : seg;
        s_sel_d   = (ACTIVE_LOW != 0) ? ~dig_sel : dig_sel;
        same      = (s_seg_d == s_seg_q) && (s_sel_d == s_sel_q);

        cnt_d     = cnt_q;
        if (!same)
            cnt_d = '0;
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + CW'(1);

        // Only the STABLE-1 -> STABLE step commits, so a held input commits once.
        commit    = same && (cnt_q == CNT_LAST);
        sel_none  = (s_sel_q == '0);
        sel_multi = (s_sel_q & (s_sel_q - DIGITS'(1))) != '0;

        bcd_d     = bcd_q;
        valid_d   = valid_q;
        update_d  = 1'b0;
        new_err   = 1'b0;

        if (commit && !sel_none) begin
            if (sel_multi) begin
                new_err = 1'b1;
            end else if (dec_legal) begin
                update_d = 1'b1;
                for (int i = 0; i < DIGITS; i++) begin
                    if (s_sel_q[i]) begin
                        bcd_d[4*i +: 4] = dec_bcd;
                        valid_d[i]      = 1'b1;
                    end
                end
            end else begin
                new_err = 1'b1;
                for (int i = 0; i < DIGITS; i++) begin
                    if (s_sel_q[i])
                        valid_d[i] = 1'b0;
                end
            end
        end

        // A fresh error outranks a simultaneous clear.
        if (new_err)
            error_d = 1'b1;
        else if (err_clear)
            error_d = 1'b0;
        else
            error_d = error_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s_seg_q  <= '0;
            s_sel_q  <= '0;
            cnt_q    <= '0;
            bcd_q    <= '0;
            valid_q  <= '0;
            update_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            s_seg_q  <= s_seg_d;
            s_sel_q  <= s_sel_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
            valid_q  <= valid_d;
            update_q <= update_d;
            error_q  <= error_d;
        end
    end

    assign bcd         = bcd_q;
    assign digit_valid = valid_q;
    assign update      = update_q;
    assign error       = error_q;

endmodule

// File: tb/tb_seg_reader.sv
// Self-checking bench for seg_reader: hand-computed vector table, corner-case
// sequences, and randomized traffic checked against a run-length reference model.
module tb_seg_reader;

    localparam int DIGITS = 4;
    localparam int STABLE = 4;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic [6:0]           seg = '0;
    logic [DIGITS-1:0]    dig_sel = '0;
    logic                 err_clear = 1'b0;
    logic [4*DIGITS-1:0]  bcd;
    logic [DIGITS-1:0]    digit_valid;
    logic                 update;
    logic                 error;

    logic [6:0]           seg_n = ~7'h7E;
    logic [DIGITS-1:0]    sel_n = ~4'b0001;
    logic                 clr1 = 1'b0;
    logic [4*DIGITS-1:0]  bcd1;
    logic [DIGITS-1:0]    valid1;
    logic                 update1;
    logic                 error1;

    always #5 clock = ~clock;

    seg_reader #(.DIGITS(DIGITS), .STABLE(STABLE), .ACTIVE_LOW(0)) dut (
        .clock(clock), .reset(reset), .seg(seg), .dig_sel(dig_sel),
        .err_clear(err_clear), .bcd(bcd), .digit_valid(digit_valid),
        .update(update), .error(error)
    );

    seg_reader #(.DIGITS(DIGITS), .STABLE(STABLE), .ACTIVE_LOW(1)) dut_n (
        .clock(clock), .reset(reset), .seg(seg_n), .dig_sel(sel_n),
        .err_clear(clr1), .bcd(bcd1), .digit_valid(valid1),
        .update(update1), .error(error1)
    );

    int n_chk = 0;
    int n_pass = 0;
    int upd_seen = 0;

    // Reference model: length of the current run of identical samples.
    logic [6:0]          m_seg = '0;
    logic [DIGITS-1:0]   m_sel = '0;
    int                  m_run = 0;
    logic [4*DIGITS-1:0] m_bcd = '0;
    logic [DIGITS-1:0]   m_valid = '0;
    logic                m_upd = 1'b0;
    logic                m_err = 1'b0;
    logic [6:0]          pat [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic ref_decode(input logic [6:0] s, output logic ok, output logic [3:0] d);
        ok = 1'b0;
        d  = 4'd0;
        for (int k = 0; k < 10; k++)
            if (pat[k] == s) begin ok = 1'b1; d = 4'(k); end
    endtask

    task automatic model_step(input logic r, input logic [6:0] s, input logic [DIGITS-1:0] sl,
                              input logic clr);
        logic nerr, ok;
        logic [3:0] d;
        int idx;
        if (r) begin
            m_seg = '0; m_sel = '0; m_run = 0; m_bcd = '0;
            m_valid = '0; m_upd = 1'b0; m_err = 1'b0;
            return;
        end
        m_upd = 1'b0;
        nerr  = 1'b0;
        if (s == m_seg && sl == m_sel) begin
            if (m_run < STABLE) begin
                m_run++;
                if (m_run == STABLE && $countones(sl) > 1) nerr = 1'b1;
                else if (m_run == STABLE && $countones(sl) == 1) begin
                    idx = 0;
                    for (int k = 0; k < DIGITS; k++) if (sl[k]) idx = k;
                    ref_decode(s, ok, d);
                    if (ok) begin
                        m_bcd[4*idx +: 4] = d;
                        m_valid[idx] = 1'b1;
                        m_upd = 1'b1;
                    end else begin
                        m_valid[idx] = 1'b0;
                        nerr = 1'b1;
                    end
                end
            end
        end else begin
            m_seg = s; m_sel = sl; m_run = 0;
        end
        m_err = nerr ? 1'b1 : (clr ? 1'b0 : m_err);
    endtask

    task automatic tick();
        @(posedge clock);
        model_step(reset, seg, dig_sel, err_clear);
        #1;
        if (update === 1'b1) upd_seen++;
        chk("model_bcd", 32'(bcd), 32'(m_bcd));
        chk("model_valid", 32'(digit_valid), 32'(m_valid));
        chk("model_update", 32'(update), 32'(m_upd));
        chk("model_error", 32'(error), 32'(m_err));
    endtask

    typedef struct {
        logic [6:0]  seg;
        logic [3:0]  sel;
        int          hold;
        logic [15:0] bcd;
        logic [3:0]  vld;
        logic        err;
        int          upds;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int upd_at;
        pat = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
        vecs[0] = '{7'h30, 4'b0001, 6,  16'h0201, 4'b0101, 1'b0, 1};
        vecs[1] = '{7'h79, 4'b0010, 6,  16'h0231, 4'b0111, 1'b0, 1};
        vecs[2] = '{7'h5B, 4'b0100, 6,  16'h0531, 4'b0111, 1'b0, 1};
        vecs[3] = '{7'h7B, 4'b1000, 6,  16'h9531, 4'b1111, 1'b0, 1};
        vecs[4] = '{7'h01, 4'b0010, 6,  16'h9531, 4'b1101, 1'b1, 0};
        vecs[5] = '{7'h7E, 4'b0011, 6,  16'h9531, 4'b1101, 1'b1, 0};
        vecs[6] = '{7'h00, 4'b0000, 10, 16'h9531, 4'b1101, 1'b1, 0};
        vecs[7] = '{7'h5F, 4'b0000, 10, 16'h9531, 4'b1101, 1'b1, 0};

        // Reset state
        tick(); tick();
        chk("reset_bcd", 32'(bcd), 0);
        chk("reset_valid", 32'(digit_valid), 0);
        chk("reset_update", 32'(update), 0);
        chk("reset_error", 32'(error), 0);
        reset = 1'b0;

        // Basic capture: commit on the 5th edge counting the first sample
        seg = 7'h6D; dig_sel = 4'b0100;
        upd_seen = 0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (t == 4) chk("basic_pre_nibble", 32'(bcd[11:8]), 0);
            if (t == 5) chk("basic_update_edge", 32'(update), 1);
        end
        chk("basic_nibble", 32'(bcd[11:8]), 2);
        chk("basic_valid", 32'(digit_valid), 32'(4'b0100));
        chk("basic_upd_count", 32'(upd_seen), 1);
        chk("basic_error", 32'(error), 0);

        // Table: full scan, illegal pattern, multi-hot select, blanking
        for (int v = 0; v < 8; v++) begin
            seg = vecs[v].seg; dig_sel = vecs[v].sel;
            upd_seen = 0;
            for (int t = 0; t < vecs[v].hold; t++) tick();
            chk($sformatf("vec%0d_bcd", v), 32'(bcd), 32'(vecs[v].bcd));
            chk($sformatf("vec%0d_valid", v), 32'(digit_valid), 32'(vecs[v].vld));
            chk($sformatf("vec%0d_error", v), 32'(error), 32'(vecs[v].err));
            chk($sformatf("vec%0d_updates", v), 32'(upd_seen), 32'(vecs[v].upds));
        end

        // err_clear alone, then err_clear colliding with a new error
        err_clear = 1'b1; tick(); err_clear = 1'b0;
        chk("clear_error", 32'(error), 0);
        seg = 7'h01; dig_sel = 4'b0010;
        for (int t = 1; t <= 4; t++) tick();
        err_clear = 1'b1; tick(); err_clear = 1'b0;
        chk("clear_vs_new_error", 32'(error), 1);
        tick();

        // Glitch: 3 x 7F, one blank sample, then 7F again
        upd_seen = 0; upd_at = -1;
        dig_sel = 4'b0001;
        for (int t = 1; t <= 10; t++) begin
            seg = (t == 4) ? 7'h00 : 7'h7F;
            tick();
            if (update === 1'b1) upd_at = t;
        end
        chk("glitch_upd_count", 32'(upd_seen), 1);
        chk("glitch_upd_edge", 32'(upd_at), 9);
        chk("glitch_nibble", 32'(bcd[3:0]), 8);

        // Blanking with a changing segment bus
        dig_sel = 4'b0000;
        for (int t = 0; t < 10; t++) begin seg = 7'($urandom); tick(); end
        chk("blank_bcd", 32'(bcd), 32'(16'h9538));

        // Reset in the middle of a window
        seg = 7'h6D; dig_sel = 4'b0100;
        tick(); tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("midreset_bcd", 32'(bcd), 0);
        chk("midreset_valid", 32'(digit_valid), 0);
        chk("midreset_error", 32'(error), 0);
        upd_at = -1;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (update === 1'b1 && upd_at < 0) upd_at = t;
        end
        chk("midreset_upd_edge", 32'(upd_at), 5);
        chk("midreset_nibble", 32'(bcd[11:8]), 2);

        // Randomized scan traffic against the model
        for (int s = 0; s < 400; s++) begin
            int r, hold;
            r = $urandom_range(0, 99);
            seg = (r < 70) ? pat[$urandom_range(0, 9)] : 7'($urandom);
            r = $urandom_range(0, 99);
            if (r < 60)      dig_sel = 4'b0001 << $urandom_range(0, 3);
            else if (r < 75) dig_sel = '0;
            else             dig_sel = 4'($urandom);
            hold = $urandom_range(1, 8);
            for (int t = 0; t < hold; t++) begin
                err_clear = ($urandom_range(0, 9) == 0);
                reset     = ($urandom_range(0, 199) == 0);
                tick();
            end
        end
        reset = 1'b0; err_clear = 1'b0;
        for (int t = 0; t < 8; t++) tick();

        // Active-low instance has seen its constant inputs since the last reset
        chk("alow_nibble", 32'(bcd1[3:0]), 0);
        chk("alow_valid", 32'(valid1), 32'(4'b0001));
        chk("alow_error", 32'(error1), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
